// File: rtl/aemb2_dwb_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aemb2_pkg
// Purpose  : Shared FSM state and transfer-size encodings for the data LSU.
// Revision : 1.0 - initial release
// ============================================================================
package aemb2_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] SIZ_B = 2'b00;
    localparam logic [1:0] SIZ_H = 2'b01;
    localparam logic [1:0] SIZ_W = 2'b10;

endpackage
`default_nettype wire

// File: rtl/aemb2_dwb_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : aemb2_dwb_lsu_if
// Purpose  : Wishbone classic data-bus bundle between the LSU and the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface aemb2_dwb_lsu_if #(
    parameter int AEMB_DWB = 32
);
    logic [AEMB_DWB-1:2] dwb_adr_o;
    logic [3:0]          dwb_sel_o;
    logic [31:0]         dwb_dat_o;
    logic                dwb_we_o;
    logic                dwb_stb_o;
    logic                dwb_cyc_o;
    logic                dwb_ack_i;
    logic [31:0]         dwb_dat_i;

    modport master (
        output dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_we_o, dwb_stb_o, dwb_cyc_o,
        input  dwb_ack_i, dwb_dat_i
    );

    modport slave (
        input  dwb_adr_o, dwb_sel_o, dwb_dat_o, dwb_we_o, dwb_stb_o, dwb_cyc_o,
        output dwb_ack_i, dwb_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/aemb2_dwb_lsu_lane.sv
`default_nettype none
// ============================================================================
// Module   : aemb2_lane
// Purpose  : Big-endian byte-lane select, store replication, load extraction.
// Revision : 1.0 - initial release
// ============================================================================
module aemb2_lane
    import aemb2_pkg::*;
(
    input  wire logic [1:0]  req_siz_i,
    input  wire logic [1:0]  req_off_i,
    input  wire logic [31:0] st_dat_i,
    output logic      [3:0]  sel_o,
    output logic      [31:0] wdat_o,
    input  wire logic [1:0]  ld_siz_i,
    input  wire logic [1:0]  ld_off_i,
    input  wire logic [31:0] ld_dat_i,
    output logic      [31:0] ld_ext_o
);

    always_comb begin
        sel_o  = 4'b1111;
        wdat_o = st_dat_i;
        case (req_siz_i)
            SIZ_B: begin
                sel_o  = 4'b1000 >> req_off_i;
                wdat_o = {4{st_dat_i[7:0]}};
            end
            SIZ_H: begin
                sel_o  = req_off_i[1] ? 4'b0011 : 4'b1100;
                wdat_o = {2{st_dat_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Offset 0 is the most significant lane.
    always_comb begin
        ld_ext_o = ld_dat_i;
        case (ld_siz_i)
            SIZ_B: begin
                case (ld_off_i)
                    2'd0:    ld_ext_o = {24'd0, ld_dat_i[31:24]};
                    2'd1:    ld_ext_o = {24'd0, ld_dat_i[23:16]};
                    2'd2:    ld_ext_o = {24'd0, ld_dat_i[15:8]};
                    default: ld_ext_o = {24'd0, ld_dat_i[7:0]};
                endcase
            end
            SIZ_H:   ld_ext_o = {16'd0, ld_off_i[1] ? ld_dat_i[15:0] : ld_dat_i[31:16]};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aemb2_dwb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : aemb2_dwb_lsu
// Purpose  : Data-side load/store unit running one Wishbone cycle per access.
// Revision : 1.0 - initial release
// ============================================================================
module aemb2_dwb_lsu
    import aemb2_pkg::*;
#(
    parameter int AEMB_DWB = 32,
    parameter int AEMB_DTO = 255
) (
    input  wire logic        gclk,
    input  wire logic        grst,
    input  wire logic        dena,
    input  wire logic        lsu_stb,
    input  wire logic        lsu_we,
    input  wire logic [1:0]  lsu_siz,
    input  wire logic [1:0]  lsu_off,
    input  wire logic [29:0] mem_ex,
    input  wire logic [31:0] lsu_dat,
    input  wire logic        msr_be,
    aemb2_dwb_lsu_if.master  dwb,
    output logic             dwb_fb,
    output logic      [31:0] lsu_rdat,
    output logic             lsu_rdy,
    output logic             lsu_err
);

    localparam int WDW = (AEMB_DTO > 1) ? $clog2(AEMB_DTO + 1) : 1;

    state_e              state_q, state_d;
    logic [AEMB_DWB-1:2] adr_q, adr_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         dat_q, dat_d;
    logic                we_q, we_d;
    logic                stb_q, stb_d;
    logic                cyc_q, cyc_d;
    logic                fb_q, fb_d;
    logic [1:0]          siz_q, siz_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         rdat_q, rdat_d;
    logic                rdy_q, rdy_d;
    logic                err_q, err_d;
    logic [WDW-1:0]      wdog_q, wdog_d;

    logic [3:0]  w_sel;
    logic [31:0] w_wdat;
    logic [31:0] w_ld;
    logic        w_wdog_hit;

    aemb2_lane u_lane (
        .req_siz_i (lsu_siz),
        .req_off_i (lsu_off),
        .st_dat_i  (lsu_dat),
        .sel_o     (w_sel),
        .wdat_o    (w_wdat),
        .ld_siz_i  (siz_q),
        .ld_off_i  (off_q),
        .ld_dat_i  (dwb.dwb_dat_i),
        .ld_ext_o  (w_ld)
    );

    // Fires on the AEMB_DTO-th BUSY cycle without ack; a zero limit never fires.
    assign w_wdog_hit = (AEMB_DTO != 0) && (wdog_q == WDW'(AEMB_DTO - 1));

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        we_d    = we_q;
        stb_d   = stb_q;
        cyc_d   = cyc_q;
        fb_d    = fb_q;
        siz_d   = siz_q;
        off_d   = off_q;
        rdat_d  = rdat_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                if (lsu_stb && dena) begin
                    state_d = BUSY;
                    adr_d   = mem_ex[AEMB_DWB-3:0];
                    sel_d   = w_sel;
                    dat_d   = w_wdat;
                    we_d    = lsu_we;
                    siz_d   = lsu_siz;
                    off_d   = lsu_off;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    fb_d    = 1'b0;
                    wdog_d  = '0;
                end else begin
                    stb_d = 1'b0;
                    cyc_d = msr_be;
                end
            end
            BUSY: begin
                if (dwb.dwb_ack_i) begin
                    if (!we_q) rdat_d = w_ld;
                    rdy_d   = 1'b1;
                    stb_d   = 1'b0;
                    cyc_d   = msr_be;
                    fb_d    = 1'b1;
                    state_d = IDLE;
                end else if (w_wdog_hit) begin
                    err_d   = 1'b1;
                    stb_d   = 1'b0;
                    cyc_d   = 1'b0;
                    fb_d    = 1'b1;
                    state_d = IDLE;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            fb_q    <= 1'b1;
            siz_q   <= '0;
            off_q   <= '0;
            rdat_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            fb_q    <= fb_d;
            siz_q   <= siz_d;
            off_q   <= off_d;
            rdat_q  <= rdat_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign dwb.dwb_adr_o = adr_q;
    assign dwb.dwb_sel_o = sel_q;
    assign dwb.dwb_dat_o = dat_q;
    assign dwb.dwb_we_o  = we_q;
    assign dwb.dwb_stb_o = stb_q;
    assign dwb.dwb_cyc_o = cyc_q;
    assign dwb_fb        = fb_q;
    assign lsu_rdat      = rdat_q;
    assign lsu_rdy       = rdy_q;
    assign lsu_err       = err_q;

endmodule
`default_nettype wire
